l0_seq_ctrl: RTL

- Sequencer for the row-parallel L0 input buffer, a bank of ROW per-row FIFOs that share one write strobe and have a staged row read-enable.
- Loads a block of NUM vectors from activation/weight SRAM into L0, then drains them into the MAC array in either aligned or diagonal (row-skewed) order.
- Pulses done once the L0 is empty.
- Sits between the top-level instruction decoder and the L0/SRAM pair.

---
 rtl/l0_seq_pkg.sv | 15 +
 rtl/l0_seq_cnt.sv | 26 ++
 rtl/l0_seq_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/l0_seq_pkg.sv
// Shared types for the L0 input-buffer sequencer: FSM state encoding and drain-mode constants.
package l0_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    localparam logic ALIGNED  = 1'b0;
    localparam logic DIAGONAL = 1'b1;

endpackage

// File: rtl/l0_seq_cnt.sv
// Loadable down-counter with a zero flag; one instance sequences the load, drain and skew phases.
module l0_seq_cnt #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && !zero)
            cnt <= cnt - W'(1);
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/l0_seq_ctrl.sv
// Sequencer that loads NUM vectors from SRAM into the row-parallel L0 and drains them aligned or skewed.
// Optional performance counters are compiled in when L0_SEQ_PERF_EN is defined.
module l0_seq_ctrl
    import l0_seq_pkg::*;
#(
    parameter int ROW    = 8,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_vec,
    input  logic              skew_mode,
    input  logic              l0_full,
    input  logic              l0_ready,
    output logic              sram_cen_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              l0_wr,
    output logic              l0_rd,
    output logic              l0_rd_version,
    output logic              busy,
    output logic              done,
`ifdef L0_SEQ_PERF_EN
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_job_cyc,
`endif
    output logic              err
);

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr_r;
    logic [CNT_W-1:0]    nvec_r;
    logic                mode_r;
    logic                wr_q;
    logic                err_r;
    logic                issue;
    logic                start_ok;

    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_val;
    logic                cnt_dec;
    logic [CNT_W-1:0]    cnt;
    logic                cnt_zero;

    assign start_ok = start && (num_vec != '0) && (num_vec <= CNT_W'(DEPTH));

    l0_seq_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start_ok) state_next = LOAD;
            // wr_q marks the cycle in which the last read's data is written into L0
            LOAD:  if (cnt_zero && wr_q) state_next = DRAIN;
            DRAIN: if (cnt_zero) state_next = FLUSH;
            FLUSH: if (cnt_zero && l0_ready) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue         = (state == LOAD) && !cnt_zero && !l0_full;
        sram_cen_n    = !issue;
        sram_addr     = addr_r;
        l0_wr         = wr_q;
        l0_rd         = (state == DRAIN);
        l0_rd_version = mode_r;
        busy          = (state != IDLE);
        done          = (state == DONE);
        err           = err_r;
    end

    // The single counter holds reads left in LOAD, reads left minus one in DRAIN, skew left in FLUSH.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE: begin
                cnt_load = start_ok;
                cnt_val  = num_vec;
            end
            LOAD: begin
                if (cnt_zero && wr_q) begin
                    cnt_load = 1'b1;
                    cnt_val  = nvec_r - CNT_W'(1);
                end else begin
                    cnt_dec = issue;
                end
            end
            DRAIN: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = (mode_r == DIAGONAL) ? CNT_W'(ROW - 1) : '0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            FLUSH: cnt_dec = !cnt_zero;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_r <= '0;
            nvec_r <= '0;
            mode_r <= ALIGNED;
            wr_q   <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            wr_q <= issue;
            if (state == IDLE && start) begin
                if (start_ok) begin
                    addr_r <= base_addr;
                    nvec_r <= num_vec;
                    mode_r <= skew_mode;
                    err_r  <= 1'b0;
                end else begin
                    err_r  <= 1'b1;
                end
            end else if (issue) begin
                addr_r <= addr_r + ADDR_W'(1);
            end
        end
    end

`ifdef L0_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_job_cyc   <= '0;
        end else if (state == IDLE) begin
            if (start_ok) begin
                perf_stall_cnt <= '0;
                perf_job_cyc   <= '0;
            end
        end else begin
            if (perf_job_cyc != 16'hFFFF)
                perf_job_cyc <= perf_job_cyc + 16'd1;
            if (state == LOAD && l0_full && perf_stall_cnt != 16'hFFFF)
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
